int_sequencer: RTL and testbench

- Multi-cycle interrupt controller for the 5-stage pipeline.
- Latches a rising edge on the external INT pin and waits for a safe boundary: no load-use stall, no taken branch/RET/RTI in execute.
- Then drains the front end, pushes the return PC (two words) and CCR flags onto the stack, and redirects the PC to the ISR vector.
- Masks further interrupts until RTI executes; its flush/stall outputs are OR-ed with the hazard unit's outputs.

---
 rtl/int_sequencer.sv | 156 +++++++++++++++
 tb/tb_int_sequencer.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/int_sequencer.sv
// Interrupt sequencer for the 5-stage pipeline.
// Detects a rising edge on int_in and waits until the pipeline is at a safe
// boundary. It then drains the front end, pushes the return PC (high word,
// then low word) and the CCR flags, and redirects the PC to the ISR vector.
// Further interrupts stay masked until RTI executes.
// Every output is decoded from registered state only, so none of them has a
// combinational path from an input.
module int_sequencer #(
  parameter int              PC_W     = 32,
  parameter int              DATA_W   = 16,
  parameter int              FLAG_W   = 4,
  parameter logic [PC_W-1:0] ISR_ADDR = 32'h0000_0002
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              int_in,
  input  logic [PC_W-1:0]   pc_resume,
  input  logic [FLAG_W-1:0] flags_in,
  input  logic              ldu_stall,
  input  logic              ctrl_flow,
  input  logic              mem_busy,
  input  logic              rti_exec,
  output logic              stall_pc,
  output logic              flush_fd,
  output logic              flush_de,
  output logic              push_en,
  output logic [DATA_W-1:0] push_data,
  output logic              pc_load,
  output logic [PC_W-1:0]   pc_load_val,
  output logic              in_isr
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DRAIN    = 3'd1,
    PUSH_HI  = 3'd2,
    PUSH_LO  = 3'd3,
    PUSH_FLG = 3'd4,
    JUMP     = 3'd5,
    ISR      = 3'd6
  } state_t;

  state_t            state_reg, state_next;
  logic              int_prev_reg;
  logic              pending_reg, pending_next;
  logic [PC_W-1:0]   saved_pc_reg;
  logic [FLAG_W-1:0] saved_flags_reg;
  logic              int_edge;
  logic              accept;
  logic [DATA_W-1:0] flags_ext;

  assign int_edge = int_in & ~int_prev_reg;
  // A request is taken only in IDLE, and only when no load-use stall and no
  // redirect is in execute. Otherwise the saved PC would be wrong.
  assign accept   = (state_reg == IDLE) & pending_reg & ~ldu_stall & ~ctrl_flow;

  // Pending request. The clear on accept wins over a coincident edge, and
  // any number of further edges collapse into one request.
  always_comb begin
    pending_next = pending_reg | int_edge;
    if (accept) begin
      pending_next = 1'b0;
    end
  end

  // Next-state logic. The push states hold while memory is busy, so each
  // word is written exactly once.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:     if (accept)    state_next = DRAIN;
      DRAIN:                   state_next = PUSH_HI;
      PUSH_HI:  if (!mem_busy) state_next = PUSH_LO;
      PUSH_LO:  if (!mem_busy) state_next = PUSH_FLG;
      PUSH_FLG: if (!mem_busy) state_next = JUMP;
      JUMP:                    state_next = ISR;
      ISR:      if (rti_exec)  state_next = IDLE;
      default:                 state_next = IDLE;
    endcase
  end

  // State, edge history, pending latch and the context captured on accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      int_prev_reg    <= 1'b0;
      pending_reg     <= 1'b0;
      saved_pc_reg    <= '0;
      saved_flags_reg <= '0;
    end else begin
      state_reg    <= state_next;
      int_prev_reg <= int_in;
      pending_reg  <= pending_next;
      if (accept) begin
        saved_pc_reg    <= pc_resume;
        saved_flags_reg <= flags_in;
      end
    end
  end

  // Zero-extend the saved flags to one stack word. This also works when
  // FLAG_W equals DATA_W.
  always_comb begin
    flags_ext                 = '0;
    flags_ext[FLAG_W-1:0]     = saved_flags_reg;
  end

  // Moore output decode. Data buses are forced to zero whenever their
  // enable is low.
  always_comb begin
    stall_pc    = 1'b0;
    flush_fd    = 1'b0;
    flush_de    = 1'b0;
    push_en     = 1'b0;
    push_data   = '0;
    pc_load     = 1'b0;
    pc_load_val = '0;
    in_isr      = 1'b0;
    case (state_reg)
      DRAIN: begin
        stall_pc = 1'b1;
        flush_fd = 1'b1;
        flush_de = 1'b1;
      end
      PUSH_HI: begin
        stall_pc  = 1'b1;
        flush_fd  = 1'b1;
        push_en   = 1'b1;
        push_data = saved_pc_reg[PC_W-1:DATA_W];
      end
      PUSH_LO: begin
        stall_pc  = 1'b1;
        flush_fd  = 1'b1;
        push_en   = 1'b1;
        push_data = saved_pc_reg[DATA_W-1:0];
      end
      PUSH_FLG: begin
        stall_pc  = 1'b1;
        flush_fd  = 1'b1;
        push_en   = 1'b1;
        push_data = flags_ext;
      end
      JUMP: begin
        flush_fd    = 1'b1;
        pc_load     = 1'b1;
        pc_load_val = ISR_ADDR;
      end
      ISR: begin
        in_isr = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_int_sequencer.sv
// Bench for int_sequencer. Each scenario is a task, and the tasks run in
// sequence. Expected stack words are queued when the interrupt stimulus is
// driven. A monitor pops and compares one entry for every push that the
// memory stage accepts.
module tb_int_sequencer;

  localparam int          PC_W   = 32;
  localparam int          DATA_W = 16;
  localparam int          FLAG_W = 4;
  localparam logic [31:0] ISR_V  = 32'h0000_0002;

  logic              clk;
  logic              rst;
  logic              int_in;
  logic [PC_W-1:0]   pc_resume;
  logic [FLAG_W-1:0] flags_in;
  logic              ldu_stall;
  logic              ctrl_flow;
  logic              mem_busy;
  logic              rti_exec;
  logic              stall_pc;
  logic              flush_fd;
  logic              flush_de;
  logic              push_en;
  logic [DATA_W-1:0] push_data;
  logic              pc_load;
  logic [PC_W-1:0]   pc_load_val;
  logic              in_isr;

  int checks;
  int errors;
  int push_count;
  int exp_push_total;
  logic [DATA_W-1:0] exp_q [$];
  logic [DATA_W-1:0] exp_word;

  // Expected {stall_pc, flush_fd, flush_de, push_en, pc_load, in_isr}, with
  // mem_busy low, for the cycles after an accepted edge.
  // Index 0 is the pending cycle, index 1 is DRAIN, ..., index 6 is the first
  // ISR cycle.
  logic [5:0] seq_exp [0:7] = '{6'b000000, 6'b111000, 6'b110100, 6'b110100,
                                6'b110100, 6'b010010, 6'b000001, 6'b000001};

  int_sequencer #(
    .PC_W(PC_W), .DATA_W(DATA_W), .FLAG_W(FLAG_W), .ISR_ADDR(ISR_V)
  ) dut (
    .clk(clk), .rst(rst), .int_in(int_in), .pc_resume(pc_resume),
    .flags_in(flags_in), .ldu_stall(ldu_stall), .ctrl_flow(ctrl_flow),
    .mem_busy(mem_busy), .rti_exec(rti_exec), .stall_pc(stall_pc),
    .flush_fd(flush_fd), .flush_de(flush_de), .push_en(push_en),
    .push_data(push_data), .pc_load(pc_load), .pc_load_val(pc_load_val),
    .in_isr(in_isr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [5:0] outs();
    return {stall_pc, flush_fd, flush_de, push_en, pc_load, in_isr};
  endfunction

  // Advance one cycle. Inputs change and outputs are sampled 1 time unit
  // after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_entry(input logic [31:0] pc, input logic [3:0] fl);
    exp_q.push_back(pc[31:16]);
    exp_q.push_back(pc[15:0]);
    exp_q.push_back({12'h000, fl});
    exp_push_total += 3;
  endtask

  // Scoreboard: one accepted push per cycle in which push_en is high and
  // mem_busy is low. mem_busy changes only just after posedge, so it is
  // stable here.
  always @(negedge clk) begin
    if (!rst && push_en && !mem_busy) begin
      push_count++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL push_unexpected got=%h required=no_push", push_data);
      end else begin
        exp_word = exp_q.pop_front();
        if (push_data !== exp_word) begin
          errors++;
          $display("FAIL push_data got=%h required=%h", push_data, exp_word);
        end else begin
          $display("push %h ok", push_data);
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1; int_in = 1'b0; pc_resume = '0; flags_in = '0;
    ldu_stall = 1'b0; ctrl_flow = 1'b0; mem_busy = 1'b0; rti_exec = 1'b0;
    repeat (2) step();
    checks++;
    if (outs() !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl got=%b required=%b", outs(), 6'b0);
    end
    checks++;
    if (push_data !== '0 || pc_load_val !== '0) begin
      errors++; $display("FAIL reset_data got=%h/%h required=0/0", push_data, pc_load_val);
    end
    rst = 1'b0;
    step();
    checks++;
    if (outs() !== 6'b0) begin
      errors++; $display("FAIL post_reset got=%b required=%b", outs(), 6'b0);
    end
    $display("test_reset done");
  endtask

  task automatic test_basic();
    pc_resume = 32'h0000_1234; flags_in = 4'b1010;
    expect_entry(32'h0000_1234, 4'b1010);
    int_in = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      int_in = 1'b0;
      checks++;
      if (outs() !== seq_exp[k]) begin
        errors++; $display("FAIL basic_cyc%0d got=%b required=%b", k + 1, outs(), seq_exp[k]);
      end
      checks++;
      if (pc_load_val !== (seq_exp[k][1] ? ISR_V : 32'h0)) begin
        errors++; $display("FAIL basic_pcval%0d got=%h required=%h", k + 1, pc_load_val,
                           seq_exp[k][1] ? ISR_V : 32'h0);
      end
    end
    rti_exec = 1'b1;
    step();
    rti_exec = 1'b0;
    checks++;
    if (outs() !== 6'b0) begin
      errors++; $display("FAIL basic_rti got=%b required=%b", outs(), 6'b0);
    end
    $display("test_basic done");
  endtask

  task automatic test_blockers();
    logic [31:0] pcs [0:4];
    pcs = '{32'h1111_0000, 32'h2222_0001, 32'h3333_0002, 32'h4444_0003, 32'h5555_0004};
    pc_resume = pcs[0]; flags_in = 4'h3; int_in = 1'b1; ldu_stall = 1'b1;
    // Cycles 1 and 2 are blocked by ldu_stall, cycle 3 by ctrl_flow, and
    // cycle 4 accepts.
    for (int k = 1; k <= 4; k++) begin
      step();
      int_in = 1'b0;
      pc_resume = pcs[k];
      ldu_stall = (k < 3);
      ctrl_flow = (k == 3);
      if (k == 4) begin
        flags_in = 4'h9;
        expect_entry(pcs[4], 4'h9);
      end
      checks++;
      if (outs() !== 6'b0) begin
        errors++; $display("FAIL blocked_cyc%0d got=%b required=%b", k, outs(), 6'b0);
      end
    end
    for (int k = 1; k < 8; k++) begin
      step();
      pc_resume = 32'h6666_0005; flags_in = 4'h0;
      checks++;
      if (outs() !== seq_exp[k]) begin
        errors++; $display("FAIL blockers_seq%0d got=%b required=%b", k, outs(), seq_exp[k]);
      end
    end
    rti_exec = 1'b1;
    step();
    rti_exec = 1'b0;
    $display("test_blockers done");
  endtask

  task automatic test_mem_busy();
    pc_resume = 32'h00AB_CDEF; flags_in = 4'h5;
    expect_entry(32'h00AB_CDEF, 4'h5);
    int_in = 1'b1;
    step(); int_in = 1'b0;          // pending cycle
    step();                         // DRAIN
    step();                         // PUSH_HI
    // PUSH_LO is held for three busy cycles and then counts in a fourth.
    for (int k = 0; k < 4; k++) begin
      step();
      mem_busy = (k < 3);
      checks++;
      if (outs() !== 6'b110100 || push_data !== 16'hCDEF) begin
        errors++; $display("FAIL busy_hold%0d got=%b/%h required=%b/%h", k, outs(), push_data,
                           6'b110100, 16'hCDEF);
      end
    end
    step();
    checks++;
    if (outs() !== 6'b110100 || push_data !== 16'h0005) begin
      errors++; $display("FAIL busy_flg got=%b/%h required=%b/%h", outs(), push_data,
                         6'b110100, 16'h0005);
    end
    step();
    checks++;
    if (outs() !== 6'b010010 || pc_load_val !== ISR_V) begin
      errors++; $display("FAIL busy_jump got=%b/%h required=%b/%h", outs(), pc_load_val,
                         6'b010010, ISR_V);
    end
    step();
    checks++;
    if (outs() !== 6'b000001) begin
      errors++; $display("FAIL busy_isr got=%b required=%b", outs(), 6'b000001);
    end
    $display("test_mem_busy done");
  endtask

  task automatic test_isr_edges();
    pc_resume = 32'h0BAD_F00D; flags_in = 4'hC;
    // Two edges while in the ISR are masked and merge into one request.
    for (int k = 0; k < 6; k++) begin
      int_in = (k == 0 || k == 2);
      step();
      checks++;
      if (outs() !== 6'b000001) begin
        errors++; $display("FAIL isr_masked%0d got=%b required=%b", k, outs(), 6'b000001);
      end
    end
    int_in = 1'b0;
    expect_entry(32'h0BAD_F00D, 4'hC);
    rti_exec = 1'b1;
    step();
    rti_exec = 1'b0;
    checks++;
    if (outs() !== 6'b0) begin
      errors++; $display("FAIL isr_exit got=%b required=%b", outs(), 6'b0);
    end
    for (int k = 1; k < 8; k++) begin
      step();
      checks++;
      if (outs() !== seq_exp[k]) begin
        errors++; $display("FAIL reentry_seq%0d got=%b required=%b", k, outs(), seq_exp[k]);
      end
    end
    rti_exec = 1'b1;
    step();
    rti_exec = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      checks++;
      if (outs() !== 6'b0) begin
        errors++; $display("FAIL single_entry%0d got=%b required=%b", k, outs(), 6'b0);
      end
    end
    $display("test_isr_edges done");
  endtask

  task automatic test_reset_mid();
    pc_resume = 32'h7777_8888; flags_in = 4'h1;
    // Only the high word is accepted before reset drops the request.
    exp_q.push_back(16'h7777);
    exp_push_total += 1;
    int_in = 1'b1;
    step(); int_in = 1'b0;
    step(); step(); step();         // DRAIN, PUSH_HI, PUSH_LO
    #2 rst = 1'b1;
    #1;
    checks++;
    if (outs() !== 6'b0 || push_data !== '0 || pc_load_val !== '0) begin
      errors++; $display("FAIL async_reset got=%b/%h/%h required=0", outs(), push_data, pc_load_val);
    end
    step();
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      checks++;
      if (outs() !== 6'b0) begin
        errors++; $display("FAIL after_reset%0d got=%b required=%b", k, outs(), 6'b0);
      end
    end
    $display("test_reset_mid done");
  endtask

  task automatic test_rti_idle();
    int_in = 1'b0; rti_exec = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if (outs() !== 6'b0 || push_data !== '0) begin
        errors++; $display("FAIL rti_idle%0d got=%b/%h required=%b/0", k, outs(), push_data, 6'b0);
      end
    end
    rti_exec = 1'b0;
    $display("test_rti_idle done");
  endtask

  initial begin
    checks = 0; errors = 0; push_count = 0; exp_push_total = 0;
    test_reset();
    test_basic();
    test_blockers();
    test_mem_busy();
    test_isr_edges();
    test_reset_mid();
    test_rti_idle();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL pending_expected got=%0d required=0", exp_q.size());
    end
    checks++;
    if (push_count != exp_push_total) begin
      errors++; $display("FAIL push_total got=%0d required=%0d", push_count, exp_push_total);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
